// File: rtl/memwb_writeback_stage_if.sv
// MEM/WB boundary bus: MEM-stage capture inputs, pipeline control and the registered WB-side outputs.
// The master is the upstream MEM-stage side; the slave is the MEM/WB register itself.
interface memwb_writeback_stage_if #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 6,
    parameter int CW  = 5
);
    logic           STALL;
    logic           FLUSH;
    logic [CW-1:0]  WB_MEM;
    logic [OPW-1:0] MEM_Opcode;
    logic [DW-1:0]  MEM_ALU_RESULT;
    logic [DW-1:0]  MEM_RD_DATA;
    logic [RW-1:0]  MEM_RD;
    logic [DW-1:0]  MEM_PC_4;

    logic [2:0]     WB;
    logic [OPW-1:0] WB_Opcode;
    logic [DW-1:0]  WB_ALU_RESULT;
    logic [DW-1:0]  WB_RD_Data;
    logic [RW-1:0]  WB_RD;
    logic [DW-1:0]  WB_PC_4;
    logic [DW-1:0]  WB_RD_DATA;
    logic           WB_RegWrite;

    modport master (
        output STALL, FLUSH, WB_MEM, MEM_Opcode, MEM_ALU_RESULT, MEM_RD_DATA, MEM_RD, MEM_PC_4,
        input  WB, WB_Opcode, WB_ALU_RESULT, WB_RD_Data, WB_RD, WB_PC_4, WB_RD_DATA, WB_RegWrite
    );

    modport slave (
        input  STALL, FLUSH, WB_MEM, MEM_Opcode, MEM_ALU_RESULT, MEM_RD_DATA, MEM_RD, MEM_PC_4,
        output WB, WB_Opcode, WB_ALU_RESULT, WB_RD_Data, WB_RD, WB_PC_4, WB_RD_DATA, WB_RegWrite
    );
endinterface

// File: rtl/memwb_writeback_stage.sv
// MEM/WB pipeline register with the 4:1 write-back source mux for the 5-stage MIPS core.
// Optional macro MEMWB_R0_GUARD_EN suppresses register-file writes aimed at $zero.
module memwb_writeback_stage #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 6,
    parameter int CW  = 5
) (
    input  logic                   CLK,
    input  logic                   RESET,
    memwb_writeback_stage_if.slave bus
);

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    logic [2:0]     wb_ctl_p1;
    logic [OPW-1:0] opcode_p1;
    logic [DW-1:0]  alu_p1;
    logic [DW-1:0]  rdata_p1;
    logic [RW-1:0]  rd_p1;
    logic [DW-1:0]  pc4_p1;

    function automatic logic [DW-1:0] wb_select(
        input logic [1:0]    sel,
        input logic [DW-1:0] rdata,
        input logic [DW-1:0] alu,
        input logic [DW-1:0] pc4
    );
        logic [DW-1:0] res;
        res = '0;
        case (sel)
            SEL_LOAD: res = rdata;
            SEL_ALU:  res = alu;
            SEL_LINK: res = pc4;
            default:  res = '0;
        endcase
        return res;
    endfunction

    function automatic logic reg_write_en(
        input logic          we,
        input logic [RW-1:0] rd
    );
`ifdef MEMWB_R0_GUARD_EN
        return we && (rd != '0);
`else
        // rd is consulted only by the $zero guard build; the register file protects r0 here.
        return we | (1'b0 & (|rd));
`endif
    endfunction

    // MEM -> WB boundary: flush beats stall, stall beats load
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wb_ctl_p1 <= '0;
            opcode_p1 <= '0;
            alu_p1    <= '0;
            rdata_p1  <= '0;
            rd_p1     <= '0;
            pc4_p1    <= '0;
        end else if (bus.FLUSH) begin
            wb_ctl_p1 <= '0;
            opcode_p1 <= '0;
            alu_p1    <= '0;
            rdata_p1  <= '0;
            rd_p1     <= '0;
            pc4_p1    <= '0;
        end else if (!bus.STALL) begin
            wb_ctl_p1 <= bus.WB_MEM[2:0];
            opcode_p1 <= bus.MEM_Opcode;
            alu_p1    <= bus.MEM_ALU_RESULT;
            rdata_p1  <= bus.MEM_RD_DATA;
            rd_p1     <= bus.MEM_RD;
            pc4_p1    <= bus.MEM_PC_4;
        end
    end

    // WB stage: combinational source select from the registered values
    assign bus.WB            = wb_ctl_p1;
    assign bus.WB_Opcode     = opcode_p1;
    assign bus.WB_ALU_RESULT = alu_p1;
    assign bus.WB_RD_Data    = rdata_p1;
    assign bus.WB_RD         = rd_p1;
    assign bus.WB_PC_4       = pc4_p1;
    assign bus.WB_RD_DATA    = wb_select(wb_ctl_p1[2:1], rdata_p1, alu_p1, pc4_p1);
    assign bus.WB_RegWrite   = reg_write_en(wb_ctl_p1[0], rd_p1);

endmodule

// File: tb/tb_memwb_writeback_stage.sv
// Directed bench for memwb_writeback_stage: reset, mux sweep, stall, flush priority, async reset, r0 guard.
module tb_memwb_writeback_stage;
    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int OPW = 6;
    localparam int CW  = 5;

    logic CLK;
    logic RESET;
    int   n_tests = 0;
    int   n_fail  = 0;

    memwb_writeback_stage_if #(.DW(DW), .RW(RW), .OPW(OPW), .CW(CW)) bus ();

    memwb_writeback_stage #(.DW(DW), .RW(RW), .OPW(OPW), .CW(CW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wb"},      {29'd0, bus.WB}, '0);
        chk({tag, ".opcode"},  {26'd0, bus.WB_Opcode}, '0);
        chk({tag, ".alu"},     bus.WB_ALU_RESULT, '0);
        chk({tag, ".rdata"},   bus.WB_RD_Data, '0);
        chk({tag, ".rd"},      {27'd0, bus.WB_RD}, '0);
        chk({tag, ".pc4"},     bus.WB_PC_4, '0);
        chk({tag, ".wbdata"},  bus.WB_RD_DATA, '0);
        chk({tag, ".regwr"},   {31'd0, bus.WB_RegWrite}, '0);
    endtask

    initial begin
        RESET              = 1'b1;
        bus.STALL          = 1'b0;
        bus.FLUSH          = 1'b0;
        bus.WB_MEM         = CW'($urandom);
        bus.MEM_Opcode     = OPW'($urandom);
        bus.MEM_ALU_RESULT = $urandom;
        bus.MEM_RD_DATA    = $urandom;
        bus.MEM_RD         = RW'($urandom);
        bus.MEM_PC_4       = $urandom;

        // reset held across an edge with random inputs
        #10;
        chk_all_zero("reset");

        bus.WB_MEM         = 5'b11011;
        bus.MEM_Opcode     = 6'h23;
        bus.MEM_ALU_RESULT = 32'h11112222;
        bus.MEM_RD_DATA    = 32'h33334444;
        bus.MEM_RD         = 5'd7;
        bus.MEM_PC_4       = 32'h00400010;
        #2 RESET = 1'b0;
        #1;
        chk("rel_hold.wb", {29'd0, bus.WB}, 32'd0);
        tick();
        chk("rel_load.wb",     {29'd0, bus.WB}, 32'd3);
        chk("rel_load.opcode", {26'd0, bus.WB_Opcode}, 32'h23);
        chk("rel_load.rd",     {27'd0, bus.WB_RD}, 32'd7);
        chk("rel_load.rdata",  bus.WB_RD_Data, 32'h33334444);
        chk("rel_load.pc4",    bus.WB_PC_4, 32'h00400010);
        chk("rel_load.wbdata", bus.WB_RD_DATA, 32'h11112222);
        chk("rel_load.regwr",  {31'd0, bus.WB_RegWrite}, 32'd1);

        // write-back mux sweep
        bus.MEM_RD_DATA    = 32'hDEADBEEF;
        bus.MEM_ALU_RESULT = 32'h00001234;
        bus.MEM_PC_4       = 32'h00400008;
        bus.MEM_RD         = 5'd8;
        bus.WB_MEM         = 5'b00001;
        tick();
        chk("mux00", bus.WB_RD_DATA, 32'hDEADBEEF);
        bus.WB_MEM = 5'b00011;
        #1;
        chk("mux01_before_edge", bus.WB_RD_DATA, 32'hDEADBEEF);
        tick();
        chk("mux01", bus.WB_RD_DATA, 32'h00001234);
        bus.WB_MEM = 5'b00101;
        tick();
        chk("mux10", bus.WB_RD_DATA, 32'h00400008);
        bus.WB_MEM = 5'b00111;
        tick();
        chk("mux11", bus.WB_RD_DATA, 32'h00000000);
        chk("mux11.regwr", {31'd0, bus.WB_RegWrite}, 32'd1);

        // stall holds every register
        bus.WB_MEM = 5'b00011;
        bus.MEM_RD = 5'd9;
        tick();
        chk("stall_pre.rd", {27'd0, bus.WB_RD}, 32'd9);
        bus.STALL          = 1'b1;
        bus.MEM_RD         = 5'd3;
        bus.MEM_ALU_RESULT = 32'h00005555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.rd",     {27'd0, bus.WB_RD}, 32'd9);
            chk("stall.wbdata", bus.WB_RD_DATA, 32'h00001234);
        end
        bus.STALL = 1'b0;
        tick();
        chk("stall_post.rd",     {27'd0, bus.WB_RD}, 32'd3);
        chk("stall_post.wbdata", bus.WB_RD_DATA, 32'h00005555);

        // flush wins over stall
        chk("flush_pre.wb", {29'd0, bus.WB}, 32'd3);
        bus.STALL = 1'b1;
        bus.FLUSH = 1'b1;
        tick();
        chk_all_zero("flush");
        bus.STALL = 1'b0;
        bus.FLUSH = 1'b0;

        // asynchronous reset between edges
        bus.MEM_ALU_RESULT = 32'hA5A5A5A5;
        bus.WB_MEM         = 5'b00011;
        bus.MEM_RD         = 5'd8;
        tick();
        chk("areset_pre.alu", bus.WB_ALU_RESULT, 32'hA5A5A5A5);
        #2 RESET = 1'b1;
        #1;
        chk_all_zero("areset");
        #1 RESET = 1'b0;
        tick();
        chk("areset_post.alu", bus.WB_ALU_RESULT, 32'hA5A5A5A5);

        // $zero write guard
        bus.WB_MEM         = 5'b00011;
        bus.MEM_RD         = 5'd0;
        bus.MEM_ALU_RESULT = 32'h00000077;
        tick();
`ifdef MEMWB_R0_GUARD_EN
        chk("r0.regwr", {31'd0, bus.WB_RegWrite}, 32'd0);
`else
        chk("r0.regwr", {31'd0, bus.WB_RegWrite}, 32'd1);
`endif
        chk("r0.wbdata", bus.WB_RD_DATA, 32'h00000077);
        bus.MEM_RD = 5'd8;
        tick();
        chk("r8.regwr", {31'd0, bus.WB_RegWrite}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/memwb_writeback_stage.md
Name: memwb_writeback_stage

Overview:
MEM/WB pipeline register plus write-back source select for the 5-stage MIPS core. On each clock it captures the MEM-stage control bits, opcode, ALU result, load data, destination register and PC+4. A 4:1 combinational mux then picks the value written to the register file. It sits between the data-memory stage and the register-file write port.

Parameters:
- DW, 32, datapath width (ALU result, load data, PC+4, write-back data)
- RW, 5, register index width
- OPW, 6, opcode width
- CW, 5, width of incoming MEM-stage control bundle

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- STALL  in  1  hold all pipeline registers
- FLUSH  in  1  synchronous bubble insert
- WB_MEM  in  CW  control bundle from EX/MEM; bits [2:1] MemtoReg select, bit [0] RegWrite, bits [4:3] MEM-only (dropped)
- MEM_Opcode  in  OPW  instruction opcode
- MEM_ALU_RESULT  in  DW  ALU result
- MEM_RD_DATA  in  DW  data-memory read data
- MEM_RD  in  RW  destination register index
- MEM_PC_4  in  DW  PC+4 of the instruction
- WB  out  3  registered WB_MEM[2:0]
- WB_Opcode  out  OPW  registered opcode
- WB_ALU_RESULT  out  DW  registered ALU result
- WB_RD_Data  out  DW  registered load data
- WB_RD  out  RW  registered destination index
- WB_PC_4  out  DW  registered PC+4
- WB_RD_DATA  out  DW  write-back value (mux output)
- WB_RegWrite  out  1  final register-file write enable

Behaviour:
- RESET high (asynchronous, any time): all registered outputs are 0 immediately. Consequently WB_RD_DATA = 0 and WB_RegWrite = 0.
- Register update on each rising CLK edge with RESET low. Priority: FLUSH > STALL > load.
  - FLUSH=1: all registers cleared to 0 (bubble; RegWrite=0).
  - STALL=1 with FLUSH=0: all registers hold their values.
  - Otherwise: WB<=WB_MEM[2:0], WB_Opcode<=MEM_Opcode, WB_ALU_RESULT<=MEM_ALU_RESULT, WB_RD_Data<=MEM_RD_DATA, WB_RD<=MEM_RD, WB_PC_4<=MEM_PC_4.
- Latency: one cycle from inputs to registered outputs. Mux is purely combinational from the registered values (no additional latency).
- Write-back mux, select = WB[2:1]:
  - 00: WB_RD_Data (load)
  - 01: WB_ALU_RESULT
  - 10: WB_PC_4 (JAL/link)
  - 11: constant 0
- No width conversion: every path is full DW bits, passed through unchanged.
- WB_RegWrite = WB[0]. The optional feature below can modify this.
- Reset released mid-cycle: registers stay 0 until the next rising edge, then load normally.

Optional Feature:
- Macro MEMWB_R0_GUARD_EN.
- Defined: WB_RegWrite = WB[0] AND (WB_RD != 0). Writes to $zero are suppressed at this stage.
- Undefined: WB_RegWrite = WB[0] unconditionally; the register file is responsible for $zero protection.
- WB_RD_DATA is identical in both builds.

Test Plan:
- Reset: RESET=1 for 10 time units with random inputs -> all outputs 0; WB_RD_DATA=0; after release, first edge loads inputs.
- Mux sweep: WB_MEM=5'b000x1, MEM_RD_DATA=32'hDEADBEEF, MEM_ALU_RESULT=32'h00001234, MEM_PC_4=32'h00400008. Set WB_MEM[2:1]=00/01/10/11 on successive cycles -> WB_RD_DATA = DEADBEEF / 00001234 / 00400008 / 00000000, each one cycle after the input.
- Stall: load MEM_RD=5'd9, then STALL=1 while inputs change to MEM_RD=5'd3 for 3 cycles -> WB_RD stays 9 and WB_RD_DATA is unchanged; after STALL=0, WB_RD=3 next edge.
- Flush priority: STALL=1 and FLUSH=1 together with WB_MEM=5'b00011 previously loaded -> next edge WB=0, WB_RegWrite=0, all data outputs 0.
- Async reset mid-run: assert RESET between clock edges while WB_ALU_RESULT=32'hA5A5A5A5 -> outputs go 0 without waiting for CLK.
- R0 guard: WB_MEM=5'b00011, MEM_RD=0 -> WB_RegWrite=0 with MEMWB_R0_GUARD_EN, 1 without. MEM_RD=5'd8 -> 1 in both builds.
